// File: rtl/rv32_pkg.sv
// Shared RV32 core constants: register width, address width, register count.
// REG_ZERO is the hardwired-zero register address (x0).
package rv32_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: selects a word from the flattened register
// array by address; address zero always reads as zero (x0).
// Ports: regs (flattened storage), addr (read address), data (read data).
module regfile_read_port
  import rv32_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [(2**ADDR_W)*DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]             addr,
  output logic [DATA_W-1:0]             data
);

  always_comb begin
    data = '0;
    if (addr != ADDR_W'(REG_ZERO))
      data = regs[int'(addr)*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/regfile.sv
// RV32I integer register file: x1..x31 storage, x0 hardwired to zero,
// two combinational read ports (a_rs1/rs1, a_rs2/rs2), one synchronous
// write port (a_rd, rd, we), async active-low reset (clk, rst_n).
module regfile
  import rv32_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a_rs1,
  output logic [DATA_W-1:0] rs1,
  input  logic [ADDR_W-1:0] a_rs2,
  output logic [DATA_W-1:0] rs2,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] rd,
  input  logic              we
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS*DATA_W-1:0] regs;

  // Slot 0 is a constant; x0 has no flops.
  assign regs[DATA_W-1:0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic hit;
    assign hit = we && (a_rd == ADDR_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        regs[i*DATA_W +: DATA_W] <= '0;
      else if (hit)
        regs[i*DATA_W +: DATA_W] <= rd;
    end
  end

  // Reads see pre-edge state: no write bypass, so
  // rd -> rs paths never form a combinational loop.
  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rp1 (
    .regs (regs),
    .addr (a_rs1),
    .data (rs1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rp2 (
    .regs (regs),
    .addr (a_rs2),
    .data (rs2)
  );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: directed stimulus queues expected reads,
// a monitor samples rs1/rs2 and compares against the queue.
module tb_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a_rs1;
  logic [31:0] rs1;
  logic [4:0]  a_rs2;
  logic [31:0] rs2;
  logic [4:0]  a_rd;
  logic [31:0] rd;
  logic        we;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event smp;

  regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a_rs1 (a_rs1),
    .rs1   (rs1),
    .a_rs2 (a_rs2),
    .rs2   (rs2),
    .a_rd  (a_rd),
    .rd    (rd),
    .we    (we)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: samples 1 time unit after each request, off the clock edges.
  always @(smp) begin
    exp_t e;
    #1;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL monitor: sample with empty queue");
    end else begin
      e = q.pop_front();
      if (rs1 !== e.e1 || rs2 !== e.e2) begin
        n_bad++;
        $display("FAIL %s: rs1=%h rs2=%h required %h %h",
                 e.nm, rs1, rs2, e.e1, e.e2);
      end
    end
  end

  task automatic chk(input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input string nm);
    a_rs1 = a1;
    a_rs2 = a2;
    q.push_back('{e1, e2, nm});
    -> smp;
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we   = 1'b1;
    a_rd = a;
    rd   = d;
    @(posedge clk);
    #2;
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    a_rd  = '0;
    rd    = '0;
    a_rs1 = '0;
    a_rs2 = '0;
    #2;
    for (int i = 0; i < 32; i++)
      chk(5'(i), 5'(31 - i), 32'h0, 32'h0, "reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // basic write, including pre-edge view
    @(negedge clk);
    #2;
    we   = 1'b1;
    a_rd = 5'd5;
    rd   = 32'hDEADBEEF;
    chk(5'd5, 5'd0, 32'h0, 32'h0, "pre_edge");
    @(posedge clk);
    #2;
    we = 1'b0;
    chk(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, "wr5");

    // x0 immutable
    wr(5'd0, 32'hFFFFFFFF);
    chk(5'd0, 5'd0, 32'h0, 32'h0, "x0");

    // write disabled
    wr(5'd7, 32'h12345678);
    @(negedge clk);
    #2;
    we   = 1'b0;
    a_rd = 5'd7;
    rd   = 32'hAAAAAAAA;
    @(posedge clk);
    #2;
    chk(5'd0, 5'd7, 32'h0, 32'h12345678, "we0");

    // dual port
    wr(5'd1, 32'h11111111);
    wr(5'd31, 32'h80000001);
    chk(5'd1, 5'd31, 32'h11111111, 32'h80000001, "dual");
    chk(5'd31, 5'd1, 32'h80000001, 32'h11111111, "dual_swap");
    chk(5'd31, 5'd31, 32'h80000001, 32'h80000001, "same_reg");

    // no bypass
    @(negedge clk);
    #2;
    we   = 1'b1;
    a_rd = 5'd1;
    rd   = 32'h22222222;
    chk(5'd1, 5'd31, 32'h11111111, 32'h80000001, "no_bypass");
    @(posedge clk);
    #2;
    we = 1'b0;
    chk(5'd1, 5'd1, 32'h22222222, 32'h22222222, "after_edge");
    chk(5'd5, 5'd7, 32'hDEADBEEF, 32'h12345678, "retained");

    // async reset between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    chk(5'd1, 5'd31, 32'h0, 32'h0, "async_a");
    chk(5'd5, 5'd7, 32'h0, 32'h0, "async_b");
    we   = 1'b1;
    a_rd = 5'd5;
    rd   = 32'hCAFEF00D;
    @(posedge clk);
    #2;
    we = 1'b0;
    chk(5'd5, 5'd5, 32'h0, 32'h0, "wr_in_rst");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    chk(5'd5, 5'd1, 32'h0, 32'h0, "post_rst");
    wr(5'd9, 32'h0BADC0DE);
    chk(5'd9, 5'd5, 32'h0BADC0DE, 32'h0, "first_wr");

    #4;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
